f_divider_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider sequencer. Computes in0/in1 with a radix-2 restoring division: one quotient bit per clock.
- Replaces the single-cycle combinational mantissa path with an FSM, an iteration counter and valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer. Holds one operation in flight.

---
 rtl/f_divider_seq.sv | 188 ++++++++++++++++++
 tb/tb_f_divider_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/f_divider_seq.sv
// Multi-cycle float32 divider: radix-2 restoring mantissa division, one quotient bit per clock.
// Optional F_DIV_SPECIAL_EN resolves NaN/inf/zero operands at acceptance without iterating.
module f_divider_seq #(
    parameter int unsigned FRACTION_BIT_WIDTH = 23,
    parameter int unsigned EXP_BIT_WIDTH      = 8,
    parameter int unsigned FLOAT_32_BIAS      = 127
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [FRACTION_BIT_WIDTH+EXP_BIT_WIDTH:0] in0,
    input  logic [FRACTION_BIT_WIDTH+EXP_BIT_WIDTH:0] in1,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [FRACTION_BIT_WIDTH+EXP_BIT_WIDTH:0] out,
    output logic                                      busy
);

    localparam int unsigned FLOAT_W = FRACTION_BIT_WIDTH + EXP_BIT_WIDTH + 1;
    localparam int unsigned MANT_W  = FRACTION_BIT_WIDTH + 1;
    localparam int unsigned QUO_W   = MANT_W + 1;
    localparam int unsigned REM_W   = MANT_W + 2;
    localparam int unsigned EXP_W   = EXP_BIT_WIDTH + 2;
    localparam int unsigned CNT_W   = $clog2(QUO_W);

    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'((1 << EXP_BIT_WIDTH) - 1);
    localparam logic signed [EXP_W-1:0] EXP_MIN = EXP_W'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0]        m1_q, m1_d;
    logic [REM_W-1:0]         rem_q, rem_d;
    logic [QUO_W-1:0]         quo_q, quo_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FLOAT_W-1:0]       out_q, out_d;
    logic                     out_valid_q, out_valid_d;

    logic [EXP_BIT_WIDTH-1:0]      e0, e1;
    logic [FRACTION_BIT_WIDTH-1:0] f0, f1;
    logic                          sign_in;
    logic signed [EXP_W-1:0]       exp_in;
    logic                          rem_ge;
    logic [REM_W-1:0]              rem_sub;
    logic signed [EXP_W-1:0]       exp_n;
    logic [FRACTION_BIT_WIDTH-1:0] frac_n;

    assign e0      = in0[FLOAT_W-2 -: EXP_BIT_WIDTH];
    assign e1      = in1[FLOAT_W-2 -: EXP_BIT_WIDTH];
    assign f0      = in0[FRACTION_BIT_WIDTH-1:0];
    assign f1      = in1[FRACTION_BIT_WIDTH-1:0];
    assign sign_in = in0[FLOAT_W-1] ^ in1[FLOAT_W-1];
    assign exp_in  = EXP_W'(e0) - EXP_W'(e1) + EXP_W'(FLOAT_32_BIAS);

    // Restoring step: subtract the divisor when it fits, shift the partial remainder left.
    assign rem_ge  = rem_q >= REM_W'(m1_q);
    assign rem_sub = rem_ge ? (rem_q - REM_W'(m1_q)) : rem_q;

    // Quotient lies in [0.5, 2); a clear MSB needs one extra left shift.
    assign exp_n  = quo_q[QUO_W-1] ? exp_q : (exp_q - EXP_ONE);
    assign frac_n = quo_q[QUO_W-1] ? quo_q[QUO_W-2:1] : quo_q[QUO_W-3:0];

`ifdef F_DIV_SPECIAL_EN
    logic               zero0, zero1, inf0, inf1, nan0, nan1;
    logic               spec_hit;
    logic [FLOAT_W-1:0] spec_val;

    assign zero0 = (e0 == '0);
    assign zero1 = (e1 == '0);
    assign inf0  = (e0 == '1) && (f0 == '0);
    assign inf1  = (e1 == '1) && (f1 == '0);
    assign nan0  = (e0 == '1) && (f0 != '0);
    assign nan1  = (e1 == '1) && (f1 != '0);

    always_comb begin
        spec_hit = 1'b1;
        spec_val = {sign_in, {(FLOAT_W-1){1'b0}}};
        if (nan0 || nan1 || (zero0 && zero1) || (inf0 && inf1)) begin
            spec_val = {1'b0, {EXP_BIT_WIDTH{1'b1}}, 1'b1, {(FRACTION_BIT_WIDTH-1){1'b0}}};
        end else if ((zero1 && !zero0) || (inf0 && !inf1)) begin
            spec_val = {sign_in, {EXP_BIT_WIDTH{1'b1}}, {FRACTION_BIT_WIDTH{1'b0}}};
        end else if (zero0 || inf1) begin
            spec_val = {sign_in, {(FLOAT_W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        m1_d        = m1_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign_in;
                    exp_d   = exp_in;
                    m1_d    = {1'b1, f1};
                    rem_d   = REM_W'({1'b1, f0});
                    quo_d   = '0;
                    cnt_d   = CNT_W'(QUO_W - 1);
                    state_d = DIV;
`ifdef F_DIV_SPECIAL_EN
                    if (spec_hit) begin
                        out_d       = spec_val;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end
            DIV: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[QUO_W-2:0], rem_ge};
                if (cnt_q == '0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            NORM: begin
                if (exp_n >= EXP_INF) begin
                    out_d = {sign_q, {EXP_BIT_WIDTH{1'b1}}, {FRACTION_BIT_WIDTH{1'b0}}};
                end else if (exp_n <= EXP_MIN) begin
                    out_d = {sign_q, {(FLOAT_W-1){1'b0}}};
                end else begin
                    out_d = {sign_q, exp_n[EXP_BIT_WIDTH-1:0], frac_n};
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            m1_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            m1_q        <= m1_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_f_divider_seq.sv
// Bench for f_divider_seq: vector table plus scoreboard queue, backpressure and mid-op reset.
// Latencies count the accept edge as edge 1 (27 normal, 1 for special operands).
module tb_f_divider_seq;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];

    localparam int LAT_BOUND = 100;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    f_divider_seq dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in0      (in0),
        .in1      (in1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference: wide integer division of the mantissas, then normalise and truncate.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m0, m1, q;
        int          e;
        logic [22:0] frac;
        m0 = {40'd0, 1'b1, a[22:0]};
        m1 = {40'd0, 1'b1, b[22:0]};
        q  = (m0 << 24) / m1;
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[24]) frac = q[23:1];
        else begin
            frac = q[22:0];
            e    = e - 1;
        end
        if (e >= 255)     return {a[31] ^ b[31], 8'hFF, 23'd0};
        else if (e <= 0)  return {a[31] ^ b[31], 31'd0};
        else              return {a[31] ^ b[31], 8'(e), frac};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                          input int lat, input int hold);
        int          edges;
        bit          bad;
        logic [31:0] held;
        logic [31:0] exp_val;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in0      = a;
        in1      = b;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(want);
        #1;
        in_valid = 1'b0;
        in0      = $urandom;
        in1      = $urandom;
        edges    = 1;
        bad      = 1'b0;
        @(negedge clk);
        while (!out_valid && edges < LAT_BOUND) begin
            if (!busy || in_ready) bad = 1'b1;
            in_valid = 1'($urandom);
            in0      = $urandom;
            in1      = $urandom;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("latency", 32'(edges), 32'(lat));
        chk("busy_no_ready", 32'(bad), 32'd0);
        held = out;
        bad  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in0      = $urandom;
            @(posedge clk);
            @(negedge clk);
            if (out !== held || !out_valid || in_ready || !busy) bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("backpressure_hold", 32'(bad), 32'd0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            exp_val = 32'hxxxx_xxxx;
        end else begin
            exp_val = sb_q.pop_front();
        end
        chk("result", out, exp_val);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("idle_return", 32'(in_ready), 32'd1);
        chk("out_kept", out, held);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in0       = '0;
        in1       = '0;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 27, 0};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 10};
        vecs[2] = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 27, 2};
        vecs[3] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 27, 0};
        vecs[4] = '{32'h00800000, 32'h7F000000, 32'h00000000, 27, 1};
        vecs[5] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 27, 0};
`ifdef F_DIV_SPECIAL_EN
        vecs[6] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1, 3};
        vecs[7] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0};
`else
        vecs[6] = '{32'h3F800000, 32'h00000000, 32'h7F000000, 27, 3};
        vecs[7] = '{32'h00000000, 32'h00000000, 32'h3F800000, 27, 0};
`endif

        #1;
        chk("reset_out", out, 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].want, vecs[i].lat, vecs[i].hold);

        // Abort an operation in the middle of the iteration with an asynchronous reset.
        @(negedge clk);
        in0      = 32'h40C00000;
        in1      = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk("mid_div_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 27, 0);

        // Random normal operands against the reference model.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op(a, b, model(a, b), 27, int'($urandom_range(0, 3)));
        end

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
